// File: rtl/charbuf_pkg.sv
// Shared constants, enums and address helpers for the character buffer arbiter.
// Optional clear engine is compiled in with CHARBUF_CLEAR_EN.
package charbuf_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned H_W    = 7;
    localparam int unsigned V_W    = 5;

    localparam logic [H_W-1:0]    COLS       = 7'd70;
    localparam logic [V_W-1:0]    ROWS       = 5'd30;
    localparam logic [DATA_W-1:0] CLEAR_CHAR = 8'h20;

    typedef enum logic {
        SLOT_VGA = 1'b0,
        SLOT_CPU = 1'b1
    } slot_e;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [H_W-1:0] h,
                                                    input logic [V_W-1:0] v);
        return {3'b000, h, v};
    endfunction

    function automatic logic [H_W-1:0] addr_h(input logic [ADDR_W-1:0] a);
        return a[11:5];
    endfunction

    function automatic logic [V_W-1:0] addr_v(input logic [ADDR_W-1:0] a);
        return a[4:0];
    endfunction

    // Visible grid only: upper bits clear, column and row inside the screen.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (a[14:12] == 3'b000) && (addr_h(a) < COLS) && (addr_v(a) < ROWS);
    endfunction

endpackage

// File: rtl/charbuf_clear_seq.sv
// Clear-screen sequencer: walks every visible cell (row index inner, column
// outer) writing one blank per enabled slot. Only built with CHARBUF_CLEAR_EN,
// so the default build carries no stray top-level module.
`ifdef CHARBUF_CLEAR_EN
module charbuf_clear_seq
    import charbuf_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    clr_state_e     state_q, state_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;

    // State and cell counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= CLR_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Next state, counter advance and write strobe.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        we_o    = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (start_i) begin
                    state_d = CLR_RUN;
                end
            end
            CLR_RUN: begin
                if (en_i) begin
                    we_o = 1'b1;
                    if (v_q == ROWS - 5'd1) begin
                        v_d = '0;
                        if (h_q == COLS - 7'd1) begin
                            h_d     = '0;
                            done_o  = 1'b1;
                            state_d = CLR_IDLE;
                        end else begin
                            h_d = h_q + 7'd1;
                        end
                    end else begin
                        v_d = v_q + 5'd1;
                    end
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign busy_o = (state_q == CLR_RUN);
    assign addr_o = pack_addr(h_q, v_q);

endmodule
`endif

// File: rtl/char_buf_arbiter.sv
// Time-division arbiter for the single-port character buffer RAM: even
// cycles belong to the VGA renderer, odd cycles to the CPU port or the clear
// engine. Define CHARBUF_CLEAR_EN to build the clear-screen engine.
module char_buf_arbiter
    import charbuf_pkg::*;
(
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_char,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    slot_e             phase_q;
    logic              cpu_slot;
    logic              cpu_acc;
    logic              cpu_ok;
    logic              clr_busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic [DATA_W-1:0] vga_char_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_rvalid_q;
    logic              rd_pend_q;
    logic              rd_oor_q;

    // Slot alternation, VGA slot first after reset.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            phase_q <= SLOT_VGA;
        end else begin
            phase_q <= (phase_q == SLOT_VGA) ? SLOT_CPU : SLOT_VGA;
        end
    end

    assign cpu_slot = (phase_q == SLOT_CPU);

`ifdef CHARBUF_CLEAR_EN
    logic clr_done_unused;

    charbuf_clear_seq u_clear_seq (
        .clk_i   (clk_50m),
        .rst_ni  (rst_n),
        .en_i    (cpu_slot),
        .start_i (clear_req),
        .busy_o  (clr_busy),
        .we_o    (clr_we),
        .addr_o  (clr_addr),
        .done_o  (clr_done_unused)
    );
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign clr_busy         = 1'b0;
    assign clr_we           = 1'b0;
    assign clr_addr         = '0;
`endif

    // Gated by rst_n so the RAM sees no traffic while reset is held.
    assign cpu_ready  = rst_n & cpu_slot & ~clr_busy;
    assign cpu_acc    = cpu_valid & cpu_ready;
    assign cpu_ok     = addr_in_range(cpu_addr);
    assign clear_busy = clr_busy;

    // RAM port mux: VGA slot, else clear write, else accepted CPU op.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rst_n) begin
            if (!cpu_slot) begin
                ram_addr = vga_addr;
            end else if (clr_we) begin
                ram_addr  = clr_addr;
                ram_we    = 1'b1;
                ram_wdata = CLEAR_CHAR;
            end else if (cpu_acc) begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we & cpu_ok;
                ram_wdata = cpu_wdata;
            end
        end
    end

    // Capture read data one cycle after each VGA slot or accepted CPU read.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            vga_char_q   <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            if (cpu_slot) begin
                vga_char_q <= ram_rdata;
            end
            rd_pend_q    <= cpu_acc & ~cpu_we;
            rd_oor_q     <= ~cpu_ok;
            cpu_rvalid_q <= rd_pend_q;
            if (rd_pend_q) begin
                cpu_rdata_q <= rd_oor_q ? '0 : ram_rdata;
            end
        end
    end

    assign vga_char   = vga_char_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Directed bench for char_buf_arbiter with a behavioural 1-cycle-latency RAM.
// Clear-engine cases are built when CHARBUF_CLEAR_EN is defined.
module tb_char_buf_arbiter;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [14:0] vga_addr;
    logic [7:0]  vga_char;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        clear_req;
    logic        clear_busy;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    logic [7:0]  mem [0:32767] = '{default: 8'h00};
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic        tb_phase;

    int n_tests = 0;
    int n_fail  = 0;

    char_buf_arbiter dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .vga_addr   (vga_addr),
        .vga_char   (vga_char),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk_50m = ~clk_50m;

    // Single-port RAM, read-first, data one cycle after the address.
    always @(posedge clk_50m) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Expected slot: VGA first after reset, then alternating.
    always @(posedge clk_50m) begin
        if (!rst_n) tb_phase <= 1'b0;
        else        tb_phase <= ~tb_phase;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        @(negedge clk_50m);
    endtask

    task automatic align0();
        int t = 0;
        while (tb_phase !== 1'b0 && t < 4) begin
            step();
            t++;
        end
    endtask

    task automatic cpu_write(input string tag, input logic [14:0] a, input logic [7:0] d,
                             input logic exp_we);
        align0();
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        check({tag, "_rdy0"}, 32'(cpu_ready), 32'd0);
        step();
        check({tag, "_rdy1"}, 32'(cpu_ready), 32'd1);
        check({tag, "_we"}, 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            check({tag, "_addr"}, 32'(ram_addr), 32'(a));
            check({tag, "_data"}, 32'(ram_wdata), 32'(d));
        end
        step();
        cpu_valid = 1'b0; cpu_we = 1'b0;
        check({tag, "_we_off"}, 32'(ram_we), 32'd0);
    endtask

    task automatic cpu_read(input string tag, input logic [14:0] a, input logic [7:0] exp);
        align0();
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        step();
        check({tag, "_rdy1"}, 32'(cpu_ready), 32'd1);
        check({tag, "_we"}, 32'(ram_we), 32'd0);
        check({tag, "_addr"}, 32'(ram_addr), 32'(a));
        step();
        cpu_valid = 1'b0;
        check({tag, "_rv_early"}, 32'(cpu_rvalid), 32'd0);
        step();
        check({tag, "_rv"}, 32'(cpu_rvalid), 32'd1);
        check({tag, "_data"}, 32'(cpu_rdata), 32'(exp));
        step();
        check({tag, "_rv_pulse"}, 32'(cpu_rvalid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  eh;
        logic [4:0]  ev;
        logic [14:0] last_addr;
        int          cyc, nw, bad, rdy, vga_bad, last_w, n, late;

        rst_n = 1'b0; vga_addr = 15'h0123; cpu_valid = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; clear_req = 1'b0;

        // Preload an out-of-range cell so a suppressed read is distinguishable.
        pre_we = 1'b1; pre_addr = 15'h00BF; pre_data = 8'hEE;
        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        pre_we = 1'b0;

        // 1: reset values
        check("rst_vga_char", 32'(vga_char), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        rst_n = 1'b1;
        #1;
        check("c1_vga_slot", 32'(ram_addr), 32'h0123);
        check("c1_ready", 32'(cpu_ready), 32'd0);
        step();
        check("c2_ready", 32'(cpu_ready), 32'd1);

        // 2: write h=5 v=3, then VGA fetch of that cell
        cpu_write("wr41", 15'h00A3, 8'h41, 1'b1);
        vga_addr = 15'h00A3;
        #1;
        check("vga_addr_slot", 32'(ram_addr), 32'h00A3);
        step();
        check("vga_char_1cyc", 32'(vga_char), 32'h00);
        step();
        check("vga_char_2cyc", 32'(vga_char), 32'h41);

        // 3: read back
        cpu_read("rd41", 15'h00A3, 8'h41);

        // 4: range checks
        cpu_write("wr_h70", 15'h08C0, 8'h55, 1'b0);
        cpu_write("wr_hi", 15'h10A3, 8'h77, 1'b0);
        cpu_read("rd_v31", 15'h00BF, 8'h00);
        cpu_write("wr_corner", 15'h08BD, 8'h5A, 1'b1);
        cpu_read("rd_corner", 15'h08BD, 8'h5A);
        cpu_read("rd_hi", 15'h10A3, 8'h00);
        check("mem_h70_untouched", 32'(mem[15'h08C0]), 32'h00);

`ifdef CHARBUF_CLEAR_EN
        // 5: full clear
        align0();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("clr_busy_rise", 32'(clear_busy), 32'd1);
        eh = '0; ev = '0; cyc = 0; nw = 0; bad = 0; rdy = 0; vga_bad = 0; last_w = -1;
        last_addr = '0;
        while (clear_busy && cyc < 6000) begin
            if (cpu_ready) rdy++;
            if (tb_phase == 1'b0 && (ram_addr !== vga_addr || ram_we !== 1'b0)) vga_bad++;
            if (ram_we) begin
                if (tb_phase !== 1'b1 || ram_wdata !== 8'h20 || ram_addr !== {3'b000, eh, ev}) bad++;
                nw++;
                last_w = cyc;
                last_addr = ram_addr;
                if (ev == 5'd29) begin ev = '0; eh = eh + 7'd1; end
                else ev = ev + 5'd1;
            end
            vga_addr = 15'(cyc * 37);
            step();
            cyc++;
        end
        check("clr_timeout", 32'(cyc < 6000), 32'd1);
        check("clr_writes", 32'(nw), 32'd2100);
        check("clr_bad_writes", 32'(bad), 32'd0);
        check("clr_ready_busy", 32'(rdy), 32'd0);
        check("clr_vga_slots", 32'(vga_bad), 32'd0);
        check("clr_last_addr", 32'(last_addr), 32'h08BD);
        check("clr_busy_fall", 32'(last_w), 32'(cyc - 1));
        align0();
        vga_addr = 15'h00A3;
        step();
        step();
        check("clr_vga_blank", 32'(vga_char), 32'h20);
        cpu_read("rd_after_clr", 15'h08BD, 8'h20);

        // 6: mid-run clear_req ignored, reset aborts the clear
        cpu_write("wr_late", 15'h0780, 8'h77, 1'b1);
        align0();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        eh = '0; ev = '0; cyc = 0; n = 0; bad = 0;
        while (n < 1000 && cyc < 6000) begin
            clear_req = 1'b0;
            if (ram_we) begin
                if (ram_addr !== {3'b000, eh, ev}) bad++;
                n++;
                if (ev == 5'd29) begin ev = '0; eh = eh + 7'd1; end
                else ev = ev + 5'd1;
                if (n == 500) clear_req = 1'b1;
            end
            step();
            cyc++;
        end
        clear_req = 1'b0;
        check("rst6_timeout", 32'(cyc < 6000), 32'd1);
        check("rst6_no_restart", 32'(bad), 32'd0);
        check("rst6_busy_mid", 32'(clear_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst6_we_gated", 32'(ram_we), 32'd0);
        step();
        check("rst6_busy", 32'(clear_busy), 32'd0);
        check("rst6_rvalid", 32'(cpu_rvalid), 32'd0);
        step();
        rst_n = 1'b1;
        late = 0;
        repeat (60) begin
            step();
            if (ram_we || clear_busy) late++;
        end
        check("rst6_no_more_writes", 32'(late), 32'd0);
        check("rst6_ram_untouched", 32'(mem[15'h0780]), 32'h77);
        cpu_read("rd_late", 15'h0780, 8'h77);
`else
        // Clear engine absent: request has no effect.
        align0();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("noclr_busy", 32'(clear_busy), 32'd0);
        check("noclr_ready", 32'(cpu_ready), 32'd1);
        check("noclr_we", 32'(ram_we), 32'd0);
        step();
        step();
        check("noclr_busy_later", 32'(clear_busy), 32'd0);
        cpu_read("rd_noclr", 15'h00A3, 8'h41);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
